expr_y_unpacker: RTL and testbench
==================================

Name: expr_y_unpacker

Overview:
- Receive end of the packed 90-bit expression result bus y = {y0,...,y17}.
- The bus arrives as a narrow valid/ready beat stream. The block reassembles a full frame, then emits the 18 fields one per handshake.
- Each emitted field is sign- or zero-extended according to its declared type.
- Used by the regression harness to check per-field results after a serialized transport.

Parameters:
- BEAT_W, 10, input beat width in bits. Must divide 90 (legal: 1,2,3,5,6,9,10,15,18,30,45,90).
- OUT_W, 8, width of the emitted field. Must be >= 6.
- NBEATS is a derived localparam: 90/BEAT_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accept
- in_data  input  BEAT_W  beat payload
- in_last  input  1  final beat of frame marker
- out_valid  output  1  field valid
- out_ready  input  1  field accept
- out_idx  output  5  field index 0..17
- out_data  output  OUT_W  extended field value
- out_last  output  1  high with out_idx==17
- frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: in_ready=0, out_valid=0, out_idx=0, out_data=0, out_last=0, frame_err=0. Beat counter and frame register are cleared. in_ready rises the cycle after reset deasserts.
- Frame layout:
  - The first beat carries y[89:90-BEAT_W] (MSB first). Beat k carries y[89-k*BEAT_W -: BEAT_W].
  - Field i has width 4/5/6 for i mod 3 = 0/1/2.
  - Field i is signed iff (i mod 6) >= 3, i.e. y3,y4,y5,y9,y10,y11,y15,y16,y17.
  - Field MSB positions, per 6-field group starting at 89 and stepping -30 per group: 89,85,80,74,70,65.
- Extension: signed fields are sign-extended to OUT_W; unsigned fields are zero-extended.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid && in_ready. Accepted beats shift into the frame register and increment the beat counter.
  - in_last on beat k < NBEATS-1: frame_err pulses next cycle, the partial frame is dropped, counter returns to 0, state stays COLLECT.
  - Beat NBEATS-1 accepted with in_last=0: frame_err pulses, the frame is dropped, counter returns to 0.
  - Beat NBEATS-1 accepted with in_last=1: go to EMIT, out_idx=0.
- State EMIT:
  - in_ready=0; no overlap with the next frame.
  - out_valid rises the cycle after the last beat is accepted (latency 1).
  - out_data/out_idx/out_last are registered and hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_idx increments and the next field is presented the following cycle, no bubbles.
  - Accept at out_idx==17: out_valid=0, return to COLLECT; in_ready=1 the next cycle.
- NBEATS==1 (BEAT_W=90): in_last must be 1 on every beat; otherwise frame_err.
- Reset in any state (including mid-frame or mid-emit) aborts immediately. No partial output follows.
- frame_err is a single-cycle pulse and is never asserted in EMIT.

Test Plan:
- BEAT_W=10, frame y0=4'hA, y1=5'h1F, y2=6'h3F, y3=4'h8, y4=5'h10, y5=6'h20, rest 0; out_ready held 1 -> idx0..5 = 0x0A, 0x1F, 0x3F, 0xF8, 0xF0, 0xE0; idx6..17 = 0x00; out_last only at idx17; out_valid first high 1 cycle after the 9th beat.
- Same frame, out_ready toggled 1,0,0,1 pattern -> out_data/out_idx stable while stalled; all 18 fields delivered in order, none duplicated; in_ready=0 throughout EMIT.
- in_last asserted on beat 4 -> frame_err high exactly 1 cycle, no out_valid. A following correct 9-beat frame with y17=6'h21 -> idx17 = 0xE1.
- 9 beats with in_last=0 on beat 8 -> frame_err pulse, no output. in_valid gaps between beats -> no effect on the assembled frame.
- reset asserted while out_idx==7 -> next cycle out_valid=0, out_idx=0. The next frame emits from idx0 correctly.
- BEAT_W=90, single beat all-ones with in_last=1 -> unsigned fields 0x0F/0x1F/0x3F, signed fields 0xFF. Same beat with in_last=0 -> frame_err.

Source files
------------

// File: rtl/expr_y_unpacker_if.sv
// Bundle of the beat-input and field-output handshakes of expr_y_unpacker.
// The slave view is the unpacker. The master view is the side that sends beats
// and accepts fields.
interface expr_y_unpacker_if #(
    parameter int BEAT_W = 10,
    parameter int OUT_W  = 8
);
    // Beat input stream
    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data;
    logic              in_last;

    // Field output stream
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_idx;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;

    // Framing error pulse
    logic              frame_err;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_data,
        output out_last,
        output frame_err
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_data,
        input  out_last,
        input  frame_err
    );
endinterface

// File: rtl/expr_y_unpacker.sv
// Receive end of the packed 90-bit expression result bus y = {y0,...,y17}.
// Beats arrive MSB first. They are shifted into a frame register. A complete,
// correctly terminated frame is then emitted one field per handshake. Each
// field is sign- or zero-extended to OUT_W according to its type.
module expr_y_unpacker #(
    parameter int BEAT_W = 10,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    expr_y_unpacker_if.slave  bus
);
    localparam int FRAME_W = 90;
    localparam int NFIELDS = 18;
    localparam int NBEATS  = FRAME_W / BEAT_W;
    localparam int CNT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [4:0]       LAST_IDX  = 5'd17;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [FRAME_W-1:0] frame_q,     frame_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [4:0]         out_idx_q,   out_idx_d;
    logic [OUT_W-1:0]   out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;
    logic               frame_err_q, frame_err_d;

    logic               beat_accept;
    logic               field_accept;
    logic [FRAME_W-1:0] frame_shift;
    logic [OUT_W-1:0]   field_ext [NFIELDS];

    // in_ready is registered, so a beat can only be taken while COLLECT is settled.
    assign beat_accept  = bus.in_valid && in_ready_q;
    assign field_accept = out_valid_q && bus.out_ready;

    // A single-beat frame replaces the whole register. Otherwise the new beat
    // enters at the LSB end, so the first beat ends up at y[89 -: BEAT_W].
    generate
        if (NBEATS == 1) begin : g_single_beat
            assign frame_shift = bus.in_data;
        end else begin : g_multi_beat
            assign frame_shift = {frame_q[FRAME_W-BEAT_W-1:0], bus.in_data};
        end
    endgenerate

    // Fields are extracted from the next-state frame. This lets the registered
    // out_data carry field 0 in the same cycle that out_valid first rises.
    // Within each 6-field group the widths are 4,5,6,4,5,6. The last three
    // fields of each group are signed.
    genvar gi;
    generate
        for (gi = 0; gi < NFIELDS; gi++) begin : g_field
            localparam int POS = gi % 6;
            localparam int GRP = gi / 6;
            localparam int W   = (gi % 3 == 0) ? 4 : ((gi % 3 == 1) ? 5 : 6);
            localparam int OFF = (POS == 0) ? 0  :
                                 (POS == 1) ? 4  :
                                 (POS == 2) ? 9  :
                                 (POS == 3) ? 15 :
                                 (POS == 4) ? 19 : 24;
            localparam int MSB = FRAME_W - 1 - 30 * GRP - OFF;
            localparam bit SGN = (POS >= 3);

            logic [OUT_W-1:0] ext;

            // Extend field gi from its slice of the frame to OUT_W bits.
            always_comb begin
                ext        = (SGN && frame_d[MSB]) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
                ext[W-1:0] = frame_d[MSB -: W];
            end

            assign field_ext[gi] = ext;
        end
    endgenerate

    // Next-state logic for COLLECT/EMIT and for the beat counter, frame register
    // and output handshake.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        frame_d     = frame_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_COLLECT: begin
                if (beat_accept) begin
                    frame_d = frame_shift;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        if (bus.in_last) begin
                            state_d     = ST_EMIT;
                            out_valid_d = 1'b1;
                            out_idx_d   = 5'd0;
                            out_last_d  = 1'b0;
                        end else begin
                            // The frame is full but not terminated, so drop it.
                            frame_err_d = 1'b1;
                            frame_d     = '0;
                        end
                    end else if (bus.in_last) begin
                        // The frame was terminated early, so drop the partial frame.
                        frame_err_d = 1'b1;
                        frame_d     = '0;
                        beat_cnt_d  = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_EMIT: begin
                if (field_accept) begin
                    if (out_idx_q == LAST_IDX) begin
                        state_d     = ST_COLLECT;
                        out_valid_d = 1'b0;
                        out_idx_d   = 5'd0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_idx_d  = out_idx_q + 5'd1;
                        out_last_d = (out_idx_q + 5'd1 == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        // Beats are accepted only in COLLECT. Input and output never overlap.
        in_ready_d = (state_d == ST_COLLECT);
    end

    // Select the field to present next. While stalled, frame_d and out_idx_d
    // do not change, so the registered value holds.
    always_comb begin
        out_data_d = '0;
        if (state_d == ST_EMIT && out_idx_d < 5'(NFIELDS)) begin
            out_data_d = field_ext[out_idx_d];
        end
    end

    // State and output registers. A reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            beat_cnt_q  <= '0;
            frame_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 5'd0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_q     <= frame_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_expr_y_unpacker.sv
// Self-checking bench for expr_y_unpacker.
// Two instances are used: BEAT_W=10 for the multi-beat cases and BEAT_W=90
// for the single-beat case. Expected field values are hand-computed in a table.
module tb_expr_y_unpacker;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    expr_y_unpacker_if #(.BEAT_W(10), .OUT_W(8)) if10 ();
    expr_y_unpacker_if #(.BEAT_W(90), .OUT_W(8)) if90 ();

    expr_y_unpacker #(.BEAT_W(10), .OUT_W(8)) u_dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (if10)
    );

    expr_y_unpacker #(.BEAT_W(90), .OUT_W(8)) u_dut90 (
        .clk   (clk),
        .reset (reset),
        .bus   (if90)
    );

    // Each row holds the per-field inputs and the expected extended outputs.
    typedef struct {
        logic [5:0] a_in;
        logic [7:0] a_exp;
        logic [5:0] b_in;
        logic [7:0] b_exp;
        logic [7:0] ones_exp;
    } vec_t;

    vec_t       tbl [18];
    logic [7:0] got_data [18];
    int         checks = 0;
    int         errors = 0;
    bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pack the chosen column as {y0,...,y17}, with widths 4,5,6 repeating.
    function automatic logic [89:0] build(input bit use_b);
        logic [89:0] y;
        logic [5:0]  m;
        logic [5:0]  v;
        int          w;
        y = '0;
        for (int i = 0; i < 18; i++) begin
            w = (i % 3 == 0) ? 4 : ((i % 3 == 1) ? 5 : 6);
            m = 6'((1 << w) - 1);
            v = use_b ? tbl[i].b_in : tbl[i].a_in;
            y = (y << w) | {84'd0, v & m};
        end
        return y;
    endfunction

    // Send nsend beats of y, MSB first. in_last is set on beat last_at.
    // When gaps is set, odd beats are preceded by two idle cycles.
    task automatic send10(input logic [89:0] y, input int nsend, input int last_at, input bit gaps);
        logic [89:0] sh;
        int          t;
        for (int k = 0; k < nsend; k++) begin
            @(negedge clk);
            if10.in_valid = 1'b0;
            if10.in_last  = 1'b0;
            if (gaps && (k % 2 == 1)) begin
                @(negedge clk);
                @(negedge clk);
            end
            t = 0;
            while (!if10.in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!if10.in_ready) begin
                errors++;
                checks++;
                $display("FAIL send_ready_timeout: beat %0d in_ready=0 after 50 cycles", k);
                return;
            end
            if (k == nsend - 1) check("pre_last_out_valid", {31'd0, if10.out_valid}, 32'd0);
            sh            = y >> (90 - 10 * (k + 1));
            if10.in_data  = sh[9:0];
            if10.in_last  = (k == last_at);
            if10.in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        if10.in_valid = 1'b0;
        if10.in_last  = 1'b0;
    endtask

    // Drain one emitted frame into got_data. This starts at the negedge after
    // the final beat. If toggle is set, out_ready follows the 1,0,0,1 pattern.
    task automatic recv10(input bit toggle);
        int         n;
        int         c;
        logic       stall;
        logic       rdy;
        logic [4:0] pidx;
        logic [7:0] pdata;
        n     = 0;
        c     = 0;
        stall = 1'b0;
        pidx  = '0;
        pdata = '0;
        while (n < 18 && c < 200) begin
            rdy            = toggle ? pat[c % 4] : 1'b1;
            if10.out_ready = rdy;
            check("emit_in_ready", {31'd0, if10.in_ready}, 32'd0);
            check("emit_out_valid", {31'd0, if10.out_valid}, 32'd1);
            check("emit_frame_err", {31'd0, if10.frame_err}, 32'd0);
            if (stall) begin
                check("stall_idx", {27'd0, if10.out_idx}, {27'd0, pidx});
                check("stall_data", {24'd0, if10.out_data}, {24'd0, pdata});
            end
            if (if10.out_valid && rdy) begin
                check("order_idx", {27'd0, if10.out_idx}, 32'(n));
                check("out_last", {31'd0, if10.out_last}, {31'd0, (n == 17)});
                got_data[n] = if10.out_data;
                n++;
            end
            stall = if10.out_valid && !rdy;
            pidx  = if10.out_idx;
            pdata = if10.out_data;
            c++;
            @(negedge clk);
        end
        if10.out_ready = 1'b0;
        if (n < 18) begin
            errors++;
            checks++;
            $display("FAIL recv_timeout: got %0d fields, need 18", n);
        end
        check("done_out_valid", {31'd0, if10.out_valid}, 32'd0);
        check("done_in_ready", {31'd0, if10.in_ready}, 32'd1);
    endtask

    task automatic compare_frame(input string name, input bit use_b);
        int bad;
        bad = errors;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("%s_field%0d", name, i), {24'd0, got_data[i]},
                  {24'd0, use_b ? tbl[i].b_exp : tbl[i].a_exp});
        end
        $display("frame %s: 18 fields compared, %0d wrong", name, errors - bad);
    endtask

    task automatic expect_frame_err(input string name);
        check({name, "_err_pulse"}, {31'd0, if10.frame_err}, 32'd1);
        check({name, "_no_valid"}, {31'd0, if10.out_valid}, 32'd0);
        @(negedge clk);
        check({name, "_err_clear"}, {31'd0, if10.frame_err}, 32'd0);
        check({name, "_no_valid2"}, {31'd0, if10.out_valid}, 32'd0);
        check({name, "_ready"}, {31'd0, if10.in_ready}, 32'd1);
        $display("frame %s: framing error case done", name);
    endtask

    initial begin
        logic [89:0] ya;
        logic [89:0] yb;
        int          c;

        tbl[0]  = '{6'h0A, 8'h0A, 6'h00, 8'h00, 8'h0F};
        tbl[1]  = '{6'h1F, 8'h1F, 6'h00, 8'h00, 8'h1F};
        tbl[2]  = '{6'h3F, 8'h3F, 6'h00, 8'h00, 8'h3F};
        tbl[3]  = '{6'h08, 8'hF8, 6'h00, 8'h00, 8'hFF};
        tbl[4]  = '{6'h10, 8'hF0, 6'h00, 8'h00, 8'hFF};
        tbl[5]  = '{6'h20, 8'hE0, 6'h00, 8'h00, 8'hFF};
        tbl[6]  = '{6'h00, 8'h00, 6'h05, 8'h05, 8'h0F};
        tbl[7]  = '{6'h00, 8'h00, 6'h00, 8'h00, 8'h1F};
        tbl[8]  = '{6'h00, 8'h00, 6'h00, 8'h00, 8'h3F};
        tbl[9]  = '{6'h00, 8'h00, 6'h07, 8'h07, 8'hFF};
        tbl[10] = '{6'h00, 8'h00, 6'h11, 8'hF1, 8'hFF};
        tbl[11] = '{6'h00, 8'h00, 6'h00, 8'h00, 8'hFF};
        tbl[12] = '{6'h00, 8'h00, 6'h03, 8'h03, 8'h0F};
        tbl[13] = '{6'h00, 8'h00, 6'h00, 8'h00, 8'h1F};
        tbl[14] = '{6'h00, 8'h00, 6'h2A, 8'h2A, 8'h3F};
        tbl[15] = '{6'h00, 8'h00, 6'h00, 8'h00, 8'hFF};
        tbl[16] = '{6'h00, 8'h00, 6'h00, 8'h00, 8'hFF};
        tbl[17] = '{6'h00, 8'h00, 6'h21, 8'hE1, 8'hFF};
        ya = build(1'b0);
        yb = build(1'b1);

        reset          = 1'b1;
        if10.in_valid  = 1'b0;
        if10.in_data   = '0;
        if10.in_last   = 1'b0;
        if10.out_ready = 1'b0;
        if90.in_valid  = 1'b0;
        if90.in_data   = '0;
        if90.in_last   = 1'b0;
        if90.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, if10.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, if10.out_valid}, 32'd0);
        check("rst_out_idx", {27'd0, if10.out_idx}, 32'd0);
        check("rst_out_data", {24'd0, if10.out_data}, 32'd0);
        check("rst_out_last", {31'd0, if10.out_last}, 32'd0);
        check("rst_frame_err", {31'd0, if10.frame_err}, 32'd0);
        check("rst_in_ready90", {31'd0, if90.in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, if10.in_ready}, 32'd1);
        check("post_rst_in_ready90", {31'd0, if90.in_ready}, 32'd1);
        $display("reset sequence done");

        // Frame A with out_ready held high
        send10(ya, 9, 8, 1'b0);
        check("lat_out_valid", {31'd0, if10.out_valid}, 32'd1);
        check("lat_in_ready", {31'd0, if10.in_ready}, 32'd0);
        check("lat_out_idx", {27'd0, if10.out_idx}, 32'd0);
        recv10(1'b0);
        compare_frame("A_ready", 1'b0);

        // The same frame with a stalling consumer
        send10(ya, 9, 8, 1'b0);
        recv10(1'b1);
        compare_frame("A_stall", 1'b0);

        // Early in_last on beat 4, followed by a good frame B
        send10(ya, 5, 4, 1'b0);
        expect_frame_err("early_last");
        send10(yb, 9, 8, 1'b0);
        check("B_out_valid", {31'd0, if10.out_valid}, 32'd1);
        recv10(1'b0);
        compare_frame("B", 1'b0 | 1'b1);

        // Missing in_last on beat 8, sent with gaps, then frame A with gaps
        send10(yb, 9, -1, 1'b1);
        expect_frame_err("missing_last");
        send10(ya, 9, 8, 1'b1);
        recv10(1'b0);
        compare_frame("A_gaps", 1'b0);

        // Reset during emission at out_idx 7
        send10(ya, 9, 8, 1'b0);
        c = 0;
        if10.out_ready = 1'b1;
        while (if10.out_idx != 5'd7 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("reach_idx7", {27'd0, if10.out_idx}, 32'd7);
        reset = 1'b1;
        @(negedge clk);
        if10.out_ready = 1'b0;
        check("midrst_out_valid", {31'd0, if10.out_valid}, 32'd0);
        check("midrst_out_idx", {27'd0, if10.out_idx}, 32'd0);
        check("midrst_in_ready", {31'd0, if10.in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_back", {31'd0, if10.in_ready}, 32'd1);
        check("midrst_no_valid", {31'd0, if10.out_valid}, 32'd0);
        send10(yb, 9, 8, 1'b0);
        recv10(1'b0);
        compare_frame("B_after_rst", 1'b1);

        // Single-beat instance: all-ones frame with in_last set
        c = 0;
        while (!if90.in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if90.in_data  = {90{1'b1}};
        if90.in_last  = 1'b1;
        if90.in_valid = 1'b1;
        @(negedge clk);
        if90.in_valid = 1'b0;
        if90.in_last  = 1'b0;
        check("b90_out_valid", {31'd0, if90.out_valid}, 32'd1);
        check("b90_in_ready", {31'd0, if90.in_ready}, 32'd0);
        if90.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("b90_idx%0d", i), {27'd0, if90.out_idx}, 32'(i));
            check($sformatf("b90_field%0d", i), {24'd0, if90.out_data}, {24'd0, tbl[i].ones_exp});
            check($sformatf("b90_last%0d", i), {31'd0, if90.out_last}, {31'd0, (i == 17)});
            @(negedge clk);
        end
        if90.out_ready = 1'b0;
        check("b90_done_valid", {31'd0, if90.out_valid}, 32'd0);
        check("b90_done_ready", {31'd0, if90.in_ready}, 32'd1);
        $display("frame ones90: 18 fields checked");

        // Single-beat instance: in_last missing
        if90.in_data  = {90{1'b1}};
        if90.in_last  = 1'b0;
        if90.in_valid = 1'b1;
        @(negedge clk);
        if90.in_valid = 1'b0;
        check("b90_err_pulse", {31'd0, if90.frame_err}, 32'd1);
        check("b90_err_no_valid", {31'd0, if90.out_valid}, 32'd0);
        @(negedge clk);
        check("b90_err_clear", {31'd0, if90.frame_err}, 32'd0);
        check("b90_err_no_valid2", {31'd0, if90.out_valid}, 32'd0);
        $display("frame ones90_nolast: framing error case done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
